// File: rtl/mem_pkg.sv
// mem_pkg: access modes, FSM states and word geometry shared with the memory stage
package mem_pkg;
    typedef enum logic [2:0] {LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5} memMode_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} memState_t;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between the memory stage and the data memory
interface data_mem_responder_if #(parameter int width = 32);
    logic             reqValid;
    logic             reqReady;
    logic             reqWrite;
    logic [width-1:0] reqAddr;
    logic [2:0]       reqMode;
    logic [width-1:0] reqData;
    logic             respValid;
    logic [width-1:0] respData;
    logic             respErr;
    logic             busy;
    modport master(output reqValid, reqWrite, reqAddr, reqMode, reqData,
                   input reqReady, respValid, respData, respErr, busy);
    modport slave(input reqValid, reqWrite, reqAddr, reqMode, reqData,
                  output reqReady, respValid, respData, respErr, busy);
endinterface

// File: rtl/load_align.sv
// load_align: moves the addressed byte/halfword lane to bit 0 and sign- or zero-extends it
module load_align
    import mem_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [width-1:0] word,
    input  logic [1:0]       off,
    input  logic [2:0]       mode,
    output logic [width-1:0] data
);
    logic [width-1:0] s;
    assign s = word >> {off, 3'b000};
    always_comb
        data = (mode == LB)  ? {{(width-8){s[7]}}, s[7:0]} :
               (mode == LH)  ? {{(width-16){s[15]}}, s[15:0]} :
               (mode == LBU) ? {{(width-8){1'b0}}, s[7:0]} :
               (mode == LHU) ? {{(width-16){1'b0}}, s[15:0]} : s;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency load/store responder with RISC-V lane handling
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int width      = 32,
    parameter int adrWidth   = 24,
    parameter int depthWords = 1024,
    parameter int latency    = 2
) (
    input logic clk,
    input logic rst_n,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(depthWords);

    if (latency < 1 || latency > 15) begin : g_bad_latency
        $error("latency must be 1..15");
    end
    if ((1 << AW) != depthWords || depthWords > 2 ** (adrWidth - 2)) begin : g_bad_depth
        $error("depthWords must be a power of two within the decoded address space");
    end

    memState_t        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q;
    logic [width-1:0] addr_q, data_q;
    logic [2:0]       mode_q;
    logic [width-1:0] mem [depthWords];
    logic [AW-1:0]    idx;
    logic             accept, bad_mode, misaligned, out_range, err;
    logic [3:0]       be;
    logic [width-1:0] wdata, aligned;

    assign accept = bus.reqValid && bus.reqReady;
    assign idx    = addr_q[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = (latency == 1) ? RESP : WAIT;
                cnt_d   = 4'(latency - 1);
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            mode_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q   <= bus.reqWrite;
                addr_q <= bus.reqAddr;
                mode_q <= bus.reqMode;
                data_q <= bus.reqData;
            end
        end

    // Stores accept only SB/SH/SW; loads additionally LBU/LHU
    assign bad_mode   = (mode_q[1:0] == 2'd3) || (mode_q[2] && (wr_q || mode_q[1]));
    assign misaligned = (mode_q[1:0] == 2'd1 && addr_q[0]) || (mode_q[1:0] == 2'd2 && addr_q[1:0] != 2'd0);
    assign out_range  = |addr_q[width-1:AW+2];
    assign err        = bad_mode || misaligned || out_range;

    assign be    = (mode_q[1:0] == 2'd0) ? 4'b0001 << addr_q[1:0] :
                   (mode_q[1:0] == 2'd1) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = (mode_q[1:0] == 2'd0) ? {4{data_q[7:0]}} :
                   (mode_q[1:0] == 2'd1) ? {2{data_q[15:0]}} : data_q;

    always_ff @(posedge clk)
        if (state_q == RESP && wr_q && !err)
            for (int i = 0; i < WORD_BYTES; i++)
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];

    load_align #(.width(width)) u_align (
        .word(mem[idx]),
        .off (addr_q[1:0]),
        .mode(mode_q),
        .data(aligned)
    );

    assign bus.respValid = state_q == RESP;
    assign bus.respErr   = bus.respValid && err;
    assign bus.respData  = (bus.respValid && !err && !wr_q) ? aligned : '0;
    assign bus.busy      = state_q != IDLE;
    assign bus.reqReady  = !bus.busy;
endmodule
